// File: rtl/kp_string_engine.sv
// Karplus-Strong string voice: noise-excited delay line with averaging filter, decay gain and auto-off.
// Latency: tick at cycle t -> RAM read at t, compute/write at t+1, qout/out_valid registered at t+2.
// No backpressure: one sample per tick, the mixer must accept every out_valid pulse; ticks need >= 3 cycle spacing.
module kp_string_engine #(
    parameter int DW = 24,
    parameter int NW = 16,
    parameter int AW = 15,
    parameter int GW = 12
) (
    input  logic                 a_clk,
    input  logic                 reset_n,
    input  logic                 tick,
    input  logic                 trig,
    input  logic signed [NW-1:0] noise,
    input  logic        [6:0]    velocity,
    input  logic        [AW-1:0] delay_len,
    input  logic        [GW-1:0] decay,
    input  logic        [DW-2:0] silence_thr,
    output logic signed [DW-1:0] qout,
    output logic                 out_valid,
    output logic                 active
);

    localparam int PW = NW + 8;        // excitation product width
    localparam int MW = DW + GW + 2;   // filter x gain product width (with sign guard)

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t                state;
    logic        [AW-1:0]  ptr;
    logic        [AW-1:0]  len;
    logic                  pend;
    logic signed [DW-1:0]  prev;
    logic        [DW-2:0]  peak;
    logic                  go_idle;

    // stage-1 bookkeeping for the sample whose RAM read was issued on the tick
    logic                  s1_vld;
    logic                  s1_load;
    logic        [AW-1:0]  s1_ptr;

    logic signed [DW-1:0]  mem [0:(1<<AW)-1];
    logic signed [DW-1:0]  rd_dat;

    // stage-0 decode: a pending or coincident trig restarts the note at ptr 0
    logic                  start;
    logic                  issue;
    logic        [AW-1:0]  rd_addr;
    logic        [AW-1:0]  len_clamp;

    assign start     = tick & (pend | trig);
    assign issue     = tick & (start | (state != IDLE));
    assign rd_addr   = start ? '0 : ptr;
    assign len_clamp = (delay_len < AW'(2)) ? AW'(2) : delay_len;

    // datapath: excitation, two-point average and decay gain
    logic signed [PW-1:0]  exc_p;
    logic signed [DW-1:0]  exc;
    logic signed [DW:0]    sum;
    logic signed [DW-1:0]  f;
    logic signed [MW-1:0]  prod;
    logic signed [DW-1:0]  w;
    logic        [DW-2:0]  w_mag;
    logic        [DW-2:0]  peak_n;
    logic                  wrap;

    assign exc_p  = PW'(noise) * PW'($signed({1'b0, velocity}));
    assign exc    = DW'(exc_p);
    assign sum    = (DW+1)'(rd_dat) + (DW+1)'(prev);
    assign f      = DW'(sum >>> 1);
    assign prod   = MW'(f) * MW'($signed({1'b0, decay}));
    assign w      = DW'(prod >>> GW);
    assign w_mag  = (DW-1)'(w[DW-1] ? -w : w);
    assign peak_n = (w_mag > peak) ? w_mag : peak;
    assign wrap   = (s1_ptr == len - AW'(1));

    // delay line: synchronous read on the tick, write-back one cycle later
    always_ff @(posedge a_clk) begin
        if (s1_vld) begin
            mem[s1_ptr] <= s1_load ? exc : w;
        end
        if (issue) begin
            rd_dat <= mem[rd_addr];
        end
    end

    // note FSM, pointer/filter state and registered outputs
    always_ff @(posedge a_clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= '0;
            len       <= AW'(2);
            pend      <= 1'b0;
            prev      <= '0;
            peak      <= '0;
            go_idle   <= 1'b0;
            s1_vld    <= 1'b0;
            s1_load   <= 1'b0;
            s1_ptr    <= '0;
            qout      <= '0;
            out_valid <= 1'b0;
            active    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            s1_vld    <= 1'b0;

            if (tick) begin
                pend <= 1'b0;
            end else if (trig) begin
                pend <= 1'b1;
            end

            if (start) begin
                len <= len_clamp;
            end

            if (issue) begin
                s1_vld  <= 1'b1;
                s1_load <= start | (state == LOAD);
                s1_ptr  <= rd_addr;
            end

            // the cycle after a silent wrap sample, drop the output to zero
            if (go_idle) begin
                go_idle <= 1'b0;
                qout    <= '0;
                active  <= 1'b0;
            end

            if (s1_vld) begin
                out_valid <= 1'b1;
                active    <= 1'b1;
                if (s1_load) begin
                    qout <= exc;
                    prev <= '0;
                    peak <= '0;
                    if (wrap) begin
                        ptr   <= '0;
                        state <= RUN;
                    end else begin
                        ptr   <= s1_ptr + AW'(1);
                        state <= LOAD;
                    end
                end else begin
                    qout <= f;
                    prev <= rd_dat;
                    if (wrap) begin
                        ptr  <= '0;
                        peak <= '0;
                        if (peak_n < silence_thr) begin
                            state   <= IDLE;
                            go_idle <= 1'b1;
                        end
                    end else begin
                        ptr  <= s1_ptr + AW'(1);
                        peak <= peak_n;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_kp_string_engine.sv
// Bench for kp_string_engine: directed notes, expected samples queued at issue time.
// A negedge monitor pops and compares whenever out_valid is high.
// Ticks are spaced 4 cycles apart; every wait is bounded.
module tb_kp_string_engine;
    localparam int DW = 24;
    localparam int NW = 16;
    localparam int AW = 15;
    localparam int GW = 12;

    logic                 a_clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 tick = 1'b0;
    logic                 trig = 1'b0;
    logic signed [NW-1:0] noise = '0;
    logic        [6:0]    velocity = '0;
    logic        [AW-1:0] delay_len = AW'(4);
    logic        [GW-1:0] decay = '0;
    logic        [DW-2:0] silence_thr = (DW-1)'(1);
    logic signed [DW-1:0] qout;
    logic                 out_valid;
    logic                 active;

    int total = 0;
    int bad = 0;
    int vcount = 0;
    int v0;
    int mon_e;
    int expq[$];
    int r4[8]  = '{0, 0, 0, 200, 200, 0, 0, 99};
    int r6[12] = '{0, 0, 0, 0, 0, 200, 200, 0, 0, 0, 0, 99};

    kp_string_engine #(.DW(DW), .NW(NW), .AW(AW), .GW(GW)) dut (
        .a_clk(a_clk), .reset_n(reset_n), .tick(tick), .trig(trig),
        .noise(noise), .velocity(velocity), .delay_len(delay_len),
        .decay(decay), .silence_thr(silence_thr),
        .qout(qout), .out_valid(out_valid), .active(active)
    );

    always #5 a_clk = ~a_clk;

    task automatic check(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    task automatic expect_sample(input int v);
        expq.push_back(v);
    endtask

    task automatic do_tick(input logic with_trig);
        @(posedge a_clk); #1;
        tick = 1'b1;
        trig = with_trig;
        @(posedge a_clk); #1;
        tick = 1'b0;
        trig = 1'b0;
        repeat (2) @(posedge a_clk);
    endtask

    task automatic pulse_trig();
        @(posedge a_clk); #1;
        trig = 1'b1;
        @(posedge a_clk); #1;
        trig = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (expq.size() != 0 && n < 50) begin
            @(posedge a_clk);
            n++;
        end
        check(name, expq.size(), 0);
        expq.delete();
        repeat (2) @(posedge a_clk);
    endtask

    task automatic reset_pulse();
        @(posedge a_clk); #1;
        reset_n = 1'b0;
        @(posedge a_clk); #1;
        reset_n = 1'b1;
    endtask

    // scoreboard monitor
    initial begin
        forever begin
            @(negedge a_clk);
            if (reset_n && out_valid) begin
                vcount++;
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_sample got=%0d want=none", qout);
                end else begin
                    mon_e = expq.pop_front();
                    check("sample", int'(qout), mon_e);
                    check("active_with_sample", int'(active), 1);
                end
            end
        end
    end

    initial begin
        // reset state
        repeat (3) @(posedge a_clk);
        #1 reset_n = 1'b1;
        check("rst_qout", int'(qout), 0);
        check("rst_active", int'(active), 0);
        check("rst_out_valid", int'(out_valid), 0);

        // ticks with no trig stay silent
        v0 = vcount;
        repeat (3) do_tick(1'b0);
        repeat (4) @(posedge a_clk);
        check("idle_no_valid", vcount - v0, 0);
        check("idle_qout", int'(qout), 0);

        // basic note: 4 loads of 512, then filtered loop
        noise = 16'sd256; velocity = 7'd2; delay_len = AW'(4);
        decay = GW'(4095); silence_thr = (DW-1)'(1);
        pulse_trig();
        repeat (4) begin expect_sample(512); do_tick(1'b0); end
        expect_sample(256); do_tick(1'b0);
        repeat (3) begin expect_sample(512); do_tick(1'b0); end
        expect_sample(383); do_tick(1'b0);
        drain("basic_drain");
        check("basic_active_run", int'(active), 1);

        // reset during RUN
        reset_pulse();
        check("midrst_qout", int'(qout), 0);
        check("midrst_active", int'(active), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        v0 = vcount;
        do_tick(1'b0);
        repeat (3) @(posedge a_clk);
        check("midrst_tick_no_valid", vcount - v0, 0);
        check("midrst_tick_qout", int'(qout), 0);

        // negative excitation and floor, trig coincident with tick
        noise = -16'sd1; velocity = 7'd127; delay_len = AW'(2);
        expect_sample(-127); do_tick(1'b1);
        expect_sample(-127); do_tick(1'b0);
        expect_sample(-64);  do_tick(1'b0);
        expect_sample(-127); do_tick(1'b0);

        // retrigger mid-RUN with delay_len=1 clamps to a 2-sample period
        noise = 16'sd10; velocity = 7'd1; delay_len = AW'(1);
        expect_sample(10); do_tick(1'b1);
        expect_sample(10); do_tick(1'b0);
        expect_sample(5);  do_tick(1'b0);
        expect_sample(10); do_tick(1'b0);
        expect_sample(7);  do_tick(1'b0);
        drain("retrig_drain");
        reset_pulse();

        // auto-off: zero gain dies at the first wrap
        noise = 16'sd100; velocity = 7'd1; delay_len = AW'(8);
        decay = '0; silence_thr = (DW-1)'(1);
        pulse_trig();
        repeat (8) begin expect_sample(100); do_tick(1'b0); end
        expect_sample(50); do_tick(1'b0);
        repeat (7) begin expect_sample(100); do_tick(1'b0); end
        drain("autooff_drain");
        check("autooff_active", int'(active), 0);
        check("autooff_qout", int'(qout), 0);
        v0 = vcount;
        repeat (4) do_tick(1'b0);
        repeat (3) @(posedge a_clk);
        check("autooff_no_valid", vcount - v0, 0);
        check("autooff_qout_after", int'(qout), 0);

        // tuning latch: period stays 4 after delay_len moves to 6
        velocity = 7'd1; delay_len = AW'(4); decay = GW'(4095);
        pulse_trig();
        for (int i = 0; i < 4; i++) begin
            noise = (i == 3) ? 16'sd400 : 16'sd0;
            expect_sample(int'(noise));
            do_tick(1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            expect_sample(r4[i]);
            do_tick(1'b0);
            if (i == 0) delay_len = AW'(6);
        end
        drain("tune4_drain");

        // next trig picks up the new period of 6
        pulse_trig();
        for (int i = 0; i < 6; i++) begin
            noise = (i == 5) ? 16'sd400 : 16'sd0;
            expect_sample(int'(noise));
            do_tick(1'b0);
        end
        for (int i = 0; i < 12; i++) begin
            expect_sample(r6[i]);
            do_tick(1'b0);
        end
        drain("tune6_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
